ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter; the send side of the keyboard link that ps2interface receives on.
//  Serialises one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) with the full
//  request-to-send sequence: clock inhibit, start bit, 8 data LSB-first, odd parity, stop, device ACK.
//  Drives PS2_CLK/PS2_DATA open-drain via output-enables; pad tristate sits in the top level (Game).
// PARAMETERS
//  INHIBIT_CYCLES  10000    clk cycles PS2_CLK is held low before start bit (100 us @ 100 MHz)
//  TIMEOUT_CYCLES  1500000  max clk cycles between device clock falling edges (15 ms @ 100 MHz)
//  RETRIES         2        extra attempts after a failure (used only with PS2TX_RETRY_EN)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-low reset
//  tx_data     in   8  command byte, sampled on accept
//  tx_valid    in   1  request; accepted when tx_valid & tx_ready on a rising clk edge
//  tx_ready    out  1  high only in IDLE
//  busy        out  1  high in every non-IDLE state (ps2interface ignores the bus while high)
//  tx_done     out  1  one-cycle pulse: byte ACKed and bus back to idle
//  tx_err      out  1  one-cycle pulse: NACK or timeout (after retries, if enabled)
//  ps2_clk_i   in   1  PS2_CLK pad value (asynchronous)
//  ps2_data_i  in   1  PS2_DATA pad value (asynchronous)
//  ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release
//  ps2_data_oe out  1  1 = pull PS2_DATA low, 0 = release
// BEHAVIOUR
//  - Inputs pass through 2-flop synchronisers; fall = sync_prev & ~sync_now (one-cycle strobe).
//  - Reset (rst=0, async): state IDLE, both oe=0, tx_done=0, tx_err=0, busy=0, tx_ready=1, counters 0.
//    Reset mid-transfer releases both lines immediately; the partial byte is dropped with no pulse.
//  - Frame shift reg (10b) = {stop=1, parity=~^tx_data, tx_data}; bit_cnt 4b counts falling edges 0..11.
//  - States:
//    IDLE: accept -> latch frame, bit_cnt=0, cnt=0, clk_oe=1 -> INHIBIT. tx_valid while busy is ignored.
//    INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then data_oe=1 (start bit) -> START.
//    START: one cycle with both oe=1, then clk_oe=0 -> DATA, cnt=0.
//    DATA: on fall n (n=1..10): data_oe = ~frame[n-1] (n=10 releases data as stop). After n=10 -> ACK.
//    ACK: on fall 11 sample ps2_data_i sync: 0 = ACK -> WAIT_IDLE; 1 = NACK -> FAIL.
//    WAIT_IDLE: wait until both synced lines high -> tx_done pulse, IDLE.
//    FAIL: both oe=0; tx_err pulse, IDLE (retry handling below).
//  - Timeout: in DATA/ACK/WAIT_IDLE cnt increments each cycle and clears on fall; cnt==TIMEOUT_CYCLES-1
//    -> release both lines -> FAIL.
//  - ps2_clk_oe is never asserted outside INHIBIT/START; data changes only while device clock is low.
//  - tx_done and tx_err are mutually exclusive and never asserted in the same transfer.
//  - Counter widths via $clog2 of the larger parameter; no wrap possible before compare.
// CONFIGURATION
//  PS2TX_RETRY_EN defined: FAIL with attempts < RETRIES re-enters INHIBIT with the same latched frame,
//    busy stays high, no tx_err; tx_err pulses only when attempts reach RETRIES; attempts clear on accept.
//  PS2TX_RETRY_EN undefined: first failure pulses tx_err and returns to IDLE; RETRIES unused.
// TESTING
//  1 tx 0xED, device model clocks at 12.5 kHz and ACKs -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
//    tx_done one pulse, tx_err 0, ps2_clk_oe high exactly INHIBIT_CYCLES+1 cycles.
//  2 tx 0x01 -> parity bit 0; tx 0xFF -> parity bit 1; device-received bytes match.
//  3 device NACKs (data high at fall 11) -> no macro: tx_err pulse, no tx_done;
//    macro, RETRIES=2: 3 inhibit sequences, then one tx_err pulse.
//  4 no device clocks after start -> tx_err at TIMEOUT_CYCLES after START; both oe = 0 afterwards.
//  5 rst low after fall 5 -> both oe = 0 same cycle, no pulses, tx_ready = 1 after rst high.
//  6 tx_valid held high with 0xAA during a transfer of 0xF4 -> only 0xF4 sent; 0xAA accepted after tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, device ACK, timeout.
// Define PS2TX_RETRY_EN to re-attempt a failed transfer up to RETRIES extra times.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned RETRIES        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned CntMax   = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                         : TIMEOUT_CYCLES;
    localparam int unsigned CntW     = (CntMax > 2) ? $clog2(CntMax) : 1;
    localparam int unsigned AttemptW = $clog2(RETRIES + 2);

`ifdef PS2TX_RETRY_EN
    localparam logic [AttemptW-1:0] RetryLimit = AttemptW'(RETRIES);
`else
    localparam logic [AttemptW-1:0] RetryLimit = '0;
`endif

    typedef enum logic [2:0] {
        StIdle, StInhibit, StStart, StData, StAck, StWaitIdle, StFail
    } state_e;

    state_e              state;
    logic [CntW-1:0]     cnt;
    logic [3:0]          bit_cnt;
    logic [9:0]          frame;
    logic [AttemptW-1:0] attempts;

    logic [2:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_fall;
    logic       clk_now;
    logic       data_now;
    logic       timed_out;

    // Idle-high reset values so no false falling edge appears after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
        end
    end

    assign clk_now   = clk_sync[1];
    assign clk_fall  = clk_sync[2] & ~clk_sync[1];
    assign data_now  = data_sync[1];
    assign timed_out = (cnt == CntW'(TIMEOUT_CYCLES - 1));

    assign tx_ready = (state == StIdle);
    assign busy     = (state != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            cnt         <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            attempts    <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                StIdle: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        bit_cnt    <= '0;
                        cnt        <= '0;
                        attempts   <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (cnt == CntW'(INHIBIT_CYCLES - 1)) begin
                        ps2_data_oe <= 1'b1;
                        cnt         <= '0;
                        state       <= StStart;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StStart: begin
                    ps2_clk_oe <= 1'b0;
                    cnt        <= '0;
                    state      <= StData;
                end
                StData: begin
                    if (clk_fall) begin
                        // Present frame bit n-1 after fall n; the stop bit releases the line.
                        cnt         <= '0;
                        ps2_data_oe <= ~frame[bit_cnt];
                        bit_cnt     <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9) begin
                            state <= StAck;
                        end
                    end else if (timed_out) begin
                        ps2_data_oe <= 1'b0;
                        state       <= StFail;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StAck: begin
                    if (clk_fall) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= data_now ? StFail : StWaitIdle;
                    end else if (timed_out) begin
                        state <= StFail;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StWaitIdle: begin
                    if (clk_now && data_now) begin
                        tx_done <= 1'b1;
                        state   <= StIdle;
                    end else if (timed_out) begin
                        state <= StFail;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StFail: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (attempts != RetryLimit) begin
                        attempts   <= attempts + 1'b1;
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= StInhibit;
                    end else begin
                        tx_err <= 1'b1;
                        state  <= StIdle;
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= StIdle;
                end
            endcase
        end
    end

endmodule
